// File: rtl/lowpass_fir_mc.sv
// Multichannel serial-MAC FIR low-pass filter: one shared coefficient bank,
// per-channel delay lines, one multiply-accumulate per cycle.
module lowpass_fir_mc #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [CW-1:0]         in_chan,
  input  logic                  bypass,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_chan
);

  localparam int PROD_W = WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (COEF_WIDTH - 2);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                       state;
  logic [WIDTH-1:0]             dline [CHANNELS][TAPS];
  logic [COEF_WIDTH-1:0]        coef  [TAPS];
  logic [CW-1:0]                chan;
  logic                         byp;
  logic [AW-1:0]                k;
  logic signed [ACC_W-1:0]      acc;

  logic                         chan_ok;
  logic                         addr_ok;
  logic [WIDTH-1:0]             x;
  logic [COEF_WIDTH-1:0]        c;
  logic [PROD_W-1:0]            xe;
  logic [PROD_W-1:0]            ce;
  logic [PROD_W-1:0]            prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      rounded;
  logic signed [ACC_W-1:0]      shifted;
  logic [WIDTH-1:0]             sat;

  assign in_ready = (state == IDLE);
  assign chan_ok  = ({1'b0, in_chan} < (CW+1)'(CHANNELS));
  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  // Operands are sign-extended to the full product width so an unsigned
  // multiply yields the exact signed product.
  always_comb begin
    x        = dline[chan][k];
    c        = coef[k];
    xe       = {{COEF_WIDTH{x[WIDTH-1]}}, x};
    ce       = {{WIDTH{c[COEF_WIDTH-1]}}, c};
    prod     = xe * ce;
    prod_ext = {{AW{prod[PROD_W-1]}}, prod};
    rounded  = acc + RND;
    shifted  = rounded >>> (COEF_WIDTH - 1);
    sat      = shifted[WIDTH-1:0];
    if (shifted > MAXV)
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < MINV)
      sat = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
      out_chan <= '0;
      acc      <= '0;
      k        <= '0;
      chan     <= '0;
      byp      <= 1'b0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++)
        for (int unsigned t = 0; t < TAPS; t++)
          dline[ch][t] <= '0;
      for (int unsigned t = 0; t < TAPS; t++)
        coef[t] <= (t == 0) ? {1'b0, {(COEF_WIDTH-1){1'b1}}} : '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we && addr_ok)
            coef[coef_addr] <= coef_data;
          // Out-of-range channels are consumed without touching any state.
          if (in_valid && chan_ok) begin
            for (int unsigned t = TAPS - 1; t > 0; t--)
              dline[in_chan][t] <= dline[in_chan][t-1];
            dline[in_chan][0] <= in_data;
            chan  <= in_chan;
            byp   <= bypass;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + AW'(1);
          if (k == AW'(TAPS - 1))
            state <= OUT;
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= byp ? dline[chan][0] : sat;
          out_chan  <= chan;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lowpass_fir_mc.sv
// Scoreboard bench for lowpass_fir_mc at default parameters: a longint
// reference model predicts each output at accept time.
module tb_lowpass_fir_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [0:0]  in_chan;
  logic        bypass;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [0:0]  out_chan;

  lowpass_fir_mc #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .CHANNELS(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chan(in_chan), .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [0:0]  ch;
    longint      cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  longint      cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  longint      mx[2][8];
  longint      mc[8];
  logic [15:0] last_data = '0;
  logic [0:0]  last_ch = '0;
  int          w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++)
      for (int t = 0; t < 8; t++)
        mx[ch][t] = 0;
    for (int t = 0; t < 8; t++)
      mc[t] = 0;
    mc[0] = 32767;
  endtask

  task automatic model_accept(input int ch, input logic [15:0] d, input logic b,
                              output logic [15:0] res);
    longint acc;
    for (int t = 7; t > 0; t--)
      mx[ch][t] = mx[ch][t-1];
    mx[ch][0] = longint'($signed(d));
    acc = 0;
    for (int t = 0; t < 8; t++)
      acc += mx[ch][t] * mc[t];
    acc = (acc + 16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    res = b ? d : acc[15:0];
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_chan", out_chan, mon_e.ch);
        check("latency", cyc - mon_e.cyc, 9);
        last_data = mon_e.data;
        last_ch   = mon_e.ch;
      end
    end
  end

  // Called #1 after a rising edge; leaves inputs idle #1 after the accept edge.
  task automatic send(input logic [0:0] ch, input logic [15:0] d, input logic b,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      output int waited);
    exp_t        e;
    logic [15:0] res;
    waited    = 0;
    in_valid  = 1'b1;
    in_chan   = ch;
    in_data   = d;
    bypass    = b;
    coef_we   = we;
    coef_addr = wa;
    coef_data = wd;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (we) mc[wa] = longint'($signed(wd));
    model_accept(int'(ch), d, b, res);
    e.data = res;
    e.ch   = ch;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic tx(input logic [0:0] ch, input logic [15:0] d, input logic b);
    int n;
    send(ch, d, b, 1'b0, 3'd0, 16'h0, n);
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [15:0] d, input bit upd);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (upd) mc[a] = longint'($signed(d));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_chan = '0; bypass = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);

    // Identity bank after reset
    tx(1'b0, 16'h4000, 1'b0);
    drain();

    // Moving average with in_valid held across samples
    for (int t = 0; t < 8; t++) wr_coef(3'(t), 16'h1000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'h7FFF, 1'b0, 1'b0, 3'd0, 16'h0, w);
      if (i > 0) check("ready_low_cycles", w, 9);
    end
    drain();

    // Channel isolation
    tx(1'b1, 16'h0000, 1'b0);
    tx(1'b0, 16'h7FFF, 1'b0);
    drain();

    // Saturation both ways
    wr_coef(3'd0, 16'h7FFF, 1'b1);
    wr_coef(3'd1, 16'h7FFF, 1'b1);
    for (int t = 2; t < 8; t++) wr_coef(3'(t), 16'h0000, 1'b1);
    tx(1'b0, 16'h7FFF, 1'b0);
    tx(1'b0, 16'h7FFF, 1'b0);
    tx(1'b0, 16'h8000, 1'b0);
    tx(1'b0, 16'h8000, 1'b0);
    drain();

    // Bypass, then filtered sample that sees the bypassed one in the line
    tx(1'b1, 16'h1357, 1'b1);
    tx(1'b1, 16'h0246, 1'b0);
    drain();

    // Coefficient write in the same cycle as accept
    send(1'b0, 16'h2000, 1'b0, 1'b1, 3'd1, 16'h0000, w);
    send(1'b0, 16'h1000, 1'b0, 1'b1, 3'd0, 16'h4000, w);
    drain();

    // Coefficient write during MAC must be ignored
    wr_coef(3'd0, 16'h7FFF, 1'b1);
    tx(1'b0, 16'h1234, 1'b0);
    wr_coef(3'd0, 16'h0000, 1'b0);
    wr_coef(3'd1, 16'h7FFF, 1'b0);
    tx(1'b0, 16'h0567, 1'b0);
    drain();

    // Reset during MAC cycle 4 discards the result
    tx(1'b1, 16'h2222, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q.delete();
    model_reset();
    check("midmac_in_ready", in_ready, 1);
    check("midmac_out_valid", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    tx(1'b0, 16'h4000, 1'b0);
    drain();

    // Outputs hold while out_valid is low
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", out_valid, 0);
    check("hold_data", out_data, last_data);
    check("hold_chan", out_chan, last_ch);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
